vga_scan_compose: RTL

Raster front end for the 3-window display path. Generates the 1280x720 scan coordinates and sync timing that the window clock divider consumes. Collects the pixels returned by the three sub-window renderers. Composites them with a frame border and background into one pipelined RGB stream with matched sync.

---
 rtl/vga_scan_compose_pkg.sv | 49 ++++
 rtl/vga_timing_gen.sv | 55 +++++
 rtl/vga_scan_compose.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vga_scan_compose_pkg.sv
// Shared 720p raster constants, colour width, default window box and region classes.
package vga_scan_compose_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int RGB_W = 12;

  // 1280x720 @ 60 Hz timing, 74.25 MHz pixel clock
  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 110;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int H_TOTAL_720  = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;

  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;
  localparam int V_TOTAL_720  = V_ACTIVE_720 + V_FP_720 + V_SYNC_720 + V_BP_720;

  // Box loaded at reset, before any renderer layout has been accepted
  localparam logic [X_W-1:0] DEF_LEFT   = X_W'(220);
  localparam logic [X_W-1:0] DEF_MID1   = X_W'(500);
  localparam logic [X_W-1:0] DEF_MID2   = X_W'(780);
  localparam logic [X_W-1:0] DEF_RIGHT  = X_W'(1060);
  localparam logic [Y_W-1:0] DEF_TOP    = Y_W'(210);
  localparam logic [Y_W-1:0] DEF_BOTTOM = Y_W'(510);

  typedef enum logic [2:0] {
    BACKGROUND = 3'd0,
    BORDER     = 3'd1,
    WIN1       = 3'd2,
    WIN2       = 3'd3,
    WIN3       = 3'd4
  } region_e;

  // A box is usable only when its columns are strictly ordered and it has height
  function automatic logic box_valid(
    input logic [X_W-1:0] left,
    input logic [X_W-1:0] mid1,
    input logic [X_W-1:0] mid2,
    input logic [X_W-1:0] right,
    input logic [Y_W-1:0] top,
    input logic [Y_W-1:0] bottom
  );
    return (left < mid1) && (mid1 < mid2) && (mid2 < right) && (top < bottom);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster scan counters plus the stage-0 blanking and sync decodes.
module vga_timing_gen
  import vga_scan_compose_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACTIVE = V_ACTIVE_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           de0,
  output logic           hs0,
  output logic           vs0,
  output logic           frame_end
);

  localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Column counter runs every cycle; line counter advances on each column wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x == X_LAST) begin
      x <= '0;
      if (y == Y_LAST) y <= '0;
      else             y <= y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  // Decode visible area, sync windows and the last pixel of the frame
  always_comb begin
    de0       = (x < X_ACT) && (y < Y_ACT);
    hs0       = (x >= HS_FIRST) && (x <= HS_LAST);
    vs0       = (y >= VS_FIRST) && (y <= VS_LAST);
    frame_end = (x == X_LAST) && (y == Y_LAST);
  end

endmodule

// File: rtl/vga_scan_compose.sv
// Raster front end: scan generation, per-frame box shadowing and a two-stage
// compositor that merges three renderer streams with a border and background.
module vga_scan_compose
  import vga_scan_compose_pkg::*;
#(
  parameter int               H_ACTIVE   = H_ACTIVE_720,
  parameter int               H_FP       = H_FP_720,
  parameter int               H_SYNC     = H_SYNC_720,
  parameter int               H_BP       = H_BP_720,
  parameter int               V_ACTIVE   = V_ACTIVE_720,
  parameter int               V_FP       = V_FP_720,
  parameter int               V_SYNC     = V_SYNC_720,
  parameter int               V_BP       = V_BP_720,
  parameter logic [RGB_W-1:0] BORDER_RGB = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_RGB     = 12'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  input  logic [X_W-1:0]   left,
  input  logic [X_W-1:0]   right,
  input  logic [X_W-1:0]   mid1,
  input  logic [X_W-1:0]   mid2,
  input  logic [Y_W-1:0]   top,
  input  logic [Y_W-1:0]   bottom,
  input  logic [RGB_W-1:0] pix_1,
  input  logic [RGB_W-1:0] pix_2,
  input  logic [RGB_W-1:0] pix_3,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start
);

  logic           de0, hs0, vs0, frame_end;
  logic [X_W-1:0] sh_left, sh_mid1, sh_mid2, sh_right;
  logic [Y_W-1:0] sh_top, sh_bottom;
  region_e        region0, region1;
  logic           de1, hs1, vs1, start1;
  logic [RGB_W-1:0] pix_sel;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .de0       (de0),
    .hs0       (hs0),
    .vs0       (vs0),
    .frame_end (frame_end)
  );

  // Latch a new box only at the last pixel of a frame, and only if it is well ordered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_left   <= DEF_LEFT;
      sh_mid1   <= DEF_MID1;
      sh_mid2   <= DEF_MID2;
      sh_right  <= DEF_RIGHT;
      sh_top    <= DEF_TOP;
      sh_bottom <= DEF_BOTTOM;
    end else if (frame_end && box_valid(left, mid1, mid2, right, top, bottom)) begin
      sh_left   <= left;
      sh_mid1   <= mid1;
      sh_mid2   <= mid2;
      sh_right  <= right;
      sh_top    <= top;
      sh_bottom <= bottom;
    end
  end

  // Classify the current scan position; split columns fall to the right-hand window
  always_comb begin
    region0 = BACKGROUND;
    if ((x > sh_left) && (x < sh_right) && (y > sh_top) && (y < sh_bottom)) begin
      if (x < sh_mid1)      region0 = WIN1;
      else if (x < sh_mid2) region0 = WIN2;
      else                  region0 = WIN3;
    end else if ((((x == sh_left) || (x == sh_right)) && (y >= sh_top) && (y <= sh_bottom)) ||
                 (((y == sh_top) || (y == sh_bottom)) && (x >= sh_left) && (x <= sh_right))) begin
      region0 = BORDER;
    end
  end

  // Stage 1 lines up the classification and timing with the renderer pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region1 <= BACKGROUND;
      de1     <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      start1  <= 1'b0;
    end else begin
      region1 <= region0;
      de1     <= de0;
      hs1     <= hs0;
      vs1     <= vs0;
      start1  <= (x == '0) && (y == '0);
    end
  end

  // Pick the colour source for the stage-1 pixel
  always_comb begin
    pix_sel = BG_RGB;
    case (region1)
      WIN1:    pix_sel = pix_1;
      WIN2:    pix_sel = pix_2;
      WIN3:    pix_sel = pix_3;
      BORDER:  pix_sel = BORDER_RGB;
      default: pix_sel = BG_RGB;
    endcase
  end

  // Stage 2 output register; blanking always drives black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb         <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= de1 ? pix_sel : '0;
      hsync       <= hs1;
      vsync       <= vs1;
      de          <= de1;
      frame_start <= start1;
    end
  end

endmodule
